// File: rtl/mips_pkg.sv
// Shared MIPS definitions: datapath word width, ULA opcodes and loader FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    // ULA (ALU) operation select used by the execute stage.
    typedef enum logic [2:0] {
        ULA_AND = 3'd0,
        ULA_OR  = 3'd1,
        ULA_ADD = 3'd2,
        ULA_SUB = 3'd6,
        ULA_SLT = 3'd7
    } ula_op_t;

    // Instruction-memory loader states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RECV  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer: shifts accepted bytes into a 32-bit word.
// Latency: o_word_ready is combinational with the 4th accepted byte; o_word valid the cycle after.
// Backpressure: none of its own; the owner only asserts i_shift on a real byte handshake.
// Ports: clock/reset_n; i_clr restarts the byte count; i_shift + i_data accept one byte;
//        o_word is the assembly register; o_word_ready flags the byte completing a word.
module byte_packer
    import mips_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              i_clr,
    input  logic              i_shift,
    input  logic [BYTE_W-1:0] i_data,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_ready
);

    logic [1:0]        r_cnt;
    logic [WORD_W-1:0] r_word;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt  <= 2'd0;
            r_word <= '0;
        end else if (i_clr) begin
            r_cnt <= 2'd0;
        end else if (i_shift) begin
            // First byte ends up in bits [31:24] after four shifts.
            r_word <= {r_word[WORD_W-BYTE_W-1:0], i_data};
            r_cnt  <= r_cnt + 2'd1;   // wraps 3 -> 0 naturally
        end
    end

    assign o_word       = r_word;
    assign o_word_ready = i_shift && (r_cnt == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian byte stream into words and writes them to i_mem.
// Latency: each word is written the cycle after its 4th byte handshake; done one cycle after the last write.
// Backpressure: in_ready only in RECV, dropped during the single WRITE cycle and outside a load.
// Ports: start/num_words request a load; in_valid/in_ready/in_data carry the byte stream;
//        mem_we/mem_addr/mem_wdata drive the i_mem write port; cpu_hold stalls PC/fetch;
//        done pulses at completion; error is sticky for an oversized request.
module imem_loader
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [7:0]        num_words,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    loader_state_t     r_state;
    loader_state_t     w_state_nxt;
    logic [7:0]        r_num;
    logic [7:0]        r_idx;
    logic              r_error;

    logic              w_start_acc;
    logic              w_too_big;
    logic              w_hs;
    logic              w_last;
    logic              w_word_ready;
    logic [WORD_W-1:0] w_word;

    assign w_start_acc = (r_state == ST_IDLE) && start;
    assign w_too_big   = (32'(num_words) > DEPTH);
    assign w_hs        = in_valid && in_ready;
    // 9-bit compare so idx+1 cannot wrap before comparison.
    assign w_last      = (({1'b0, r_idx} + 9'd1) >= {1'b0, r_num});

    byte_packer u_packer (
        .clock        (clock),
        .reset_n      (reset_n),
        .i_clr        (w_start_acc),
        .i_shift      (w_hs),
        .i_data       (in_data),
        .o_word       (w_word),
        .o_word_ready (w_word_ready)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_num   <= 8'd0;
            r_idx   <= 8'd0;
            r_error <= 1'b0;
        end else if (w_start_acc) begin
            r_num   <= num_words;
            r_idx   <= 8'd0;
            r_error <= w_too_big;
        end else if (r_state == ST_WRITE) begin
            r_idx <= r_idx + 8'd1;
        end
    end

    // Outputs decode from the registered state only, so reset clears them immediately.
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = 32'd0;
        mem_wdata   = '0;
        cpu_hold    = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    // Empty or oversized requests complete without touching memory.
                    if ((num_words == 8'd0) || w_too_big) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_RECV;
                    end
                end
            end
            ST_RECV: begin
                in_ready = 1'b1;
                cpu_hold = 1'b1;
                if (w_word_ready) begin
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                cpu_hold  = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = BASE_ADDR + {22'd0, r_idx, 2'b00};
                mem_wdata = w_word;
                w_state_nxt = w_last ? ST_DONE : ST_RECV;
            end
            ST_DONE: begin
                cpu_hold    = 1'b1;
                done        = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign error = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: byte-stream loads, empty/oversized requests, stalls and mid-load reset.
// Latency: n/a.
// Backpressure: the byte driver holds each byte until in_ready is seen.
module tb_imem_loader;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [7:0]  num_words;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader #(
        .DEPTH     (64),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .num_words (num_words),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Observation log, sampled on the falling edge (one entry per cycle).
    int          cyc = 0;
    int          hs = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          start_cyc = 0;
    bit          rdy_seen = 0;
    bit          hold_at_done = 0;
    bit          hold_after_done = 1;
    bit          prev_done = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          wr_cyc[$];
    int          hs4_cyc[$];

    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (start) start_cyc = cyc;
            if (in_ready) rdy_seen = 1;
            if (in_valid && in_ready) begin
                hs++;
                if (hs % 4 == 0) hs4_cyc.push_back(cyc);
            end
            if (mem_we) begin
                wr_addr.push_back(mem_addr);
                wr_data.push_back(mem_wdata);
                wr_cyc.push_back(cyc);
            end
            if (prev_done) hold_after_done = cpu_hold;
            if (done) begin
                done_cnt++;
                done_cyc     = cyc;
                hold_at_done = cpu_hold;
            end
            prev_done = done;
        end
    end

    task automatic clr_log();
        hs = 0;
        done_cnt = 0;
        rdy_seen = 0;
        hold_at_done = 0;
        hold_after_done = 1;
        wr_addr.delete();
        wr_data.delete();
        wr_cyc.delete();
        hs4_cyc.delete();
    endtask

    // All driver tasks start and end 1 time unit after a rising edge.
    task automatic do_start(input logic [7:0] n);
        start     = 1'b1;
        num_words = n;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int  g;
        bit  sent;
        g    = gaps ? int'($urandom_range(0, 2)) : 0;
        sent = 0;
        repeat (g) begin
            in_valid = 1'b0;
            @(posedge clock); #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 40 && !sent; t++) begin
            @(negedge clock);
            if (in_ready) sent = 1;
            @(posedge clock); #1;
            if (!sent && (t % 2 == 1) && gaps) begin
                // Occasional valid drop while waiting, must not lose the byte.
                in_valid = 1'b0;
                @(posedge clock); #1;
                in_valid = 1'b1;
            end
        end
        if (!sent) chk("byte_accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        logic [31:0] v;
        v = w;
        send_byte(v[31:24], gaps);
        send_byte(v[23:16], gaps);
        send_byte(v[15:8],  gaps);
        send_byte(v[7:0],   gaps);
    endtask

    task automatic chk_wr(input string pfx, input int k, input logic [31:0] a, input logic [31:0] d);
        if (wr_addr.size() > k) begin
            chk({pfx, "_addr"}, wr_addr[k], a);
            chk({pfx, "_data"}, wr_data[k], d);
            if (hs4_cyc.size() > k) chk({pfx, "_latency"}, wr_cyc[k] - hs4_cyc[k], 32'd1);
        end
    endtask

    task automatic chk_outs_zero(input string pfx);
        chk({pfx, "_in_ready"},  {31'd0, in_ready}, 32'd0);
        chk({pfx, "_mem_we"},    {31'd0, mem_we},   32'd0);
        chk({pfx, "_cpu_hold"},  {31'd0, cpu_hold}, 32'd0);
        chk({pfx, "_done"},      {31'd0, done},     32'd0);
        chk({pfx, "_error"},     {31'd0, error},    32'd0);
        chk({pfx, "_mem_addr"},  mem_addr,          32'd0);
        chk({pfx, "_mem_wdata"}, mem_wdata,         32'd0);
    endtask

    initial begin
        reset_n   = 1'b1;
        start     = 1'b0;
        num_words = 8'd0;
        in_valid  = 1'b0;
        in_data   = 8'd0;
        #2 reset_n = 1'b0;
        #10;
        chk_outs_zero("rst");
        @(posedge clock); #1;
        reset_n = 1'b1;
        @(posedge clock); #1;

        // Two-word load, back-to-back bytes.
        clr_log();
        do_start(8'd2);
        send_word(32'h2008_0005, 1'b0);
        send_word(32'hAC09_0004, 1'b0);
        repeat (5) begin @(posedge clock); #1; end
        chk("s1_nwrites", wr_addr.size(), 32'd2);
        chk_wr("s1_w0", 0, 32'h0, 32'h2008_0005);
        chk_wr("s1_w1", 1, 32'h4, 32'hAC09_0004);
        chk("s1_done_cnt", done_cnt, 32'd1);
        if (wr_cyc.size() > 1) chk("s1_done_after_wr", done_cyc - wr_cyc[1], 32'd1);
        chk("s1_hold_at_done", {31'd0, hold_at_done}, 32'd1);
        chk("s1_hold_after_done", {31'd0, hold_after_done}, 32'd0);
        chk("s1_error", {31'd0, error}, 32'd0);

        // Zero-word request.
        clr_log();
        do_start(8'd0);
        repeat (4) begin @(posedge clock); #1; end
        chk("s2_done_cnt", done_cnt, 32'd1);
        chk("s2_done_lat", done_cyc - start_cyc, 32'd1);
        chk("s2_nwrites", wr_addr.size(), 32'd0);
        chk("s2_error", {31'd0, error}, 32'd0);
        chk("s2_rdy_seen", {31'd0, rdy_seen}, 32'd0);

        // Oversized request: 65 words into a 64-word memory.
        clr_log();
        do_start(8'd65);
        repeat (4) begin @(posedge clock); #1; end
        chk("s3_error", {31'd0, error}, 32'd1);
        chk("s3_done_cnt", done_cnt, 32'd1);
        chk("s3_nwrites", wr_addr.size(), 32'd0);
        chk("s3_rdy_seen", {31'd0, rdy_seen}, 32'd0);

        // Three-word load with in_valid gaps; start also clears the sticky error.
        clr_log();
        do_start(8'd3);
        chk("s4_error_cleared", {31'd0, error}, 32'd0);
        send_word(32'h3C01_1001, 1'b1);
        send_word(32'h3421_0004, 1'b1);
        send_word(32'h8C22_0008, 1'b1);
        repeat (5) begin @(posedge clock); #1; end
        chk("s4_nwrites", wr_addr.size(), 32'd3);
        chk_wr("s4_w0", 0, 32'h0, 32'h3C01_1001);
        chk_wr("s4_w1", 1, 32'h4, 32'h3421_0004);
        chk_wr("s4_w2", 2, 32'h8, 32'h8C22_0008);
        chk("s4_done_cnt", done_cnt, 32'd1);

        // start reasserted mid-load with a different count must be ignored.
        clr_log();
        do_start(8'd2);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        do_start(8'd1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        send_word(32'h5566_7788, 1'b0);
        repeat (5) begin @(posedge clock); #1; end
        chk("s5_nwrites", wr_addr.size(), 32'd2);
        chk_wr("s5_w0", 0, 32'h0, 32'h1122_3344);
        chk_wr("s5_w1", 1, 32'h4, 32'h5566_7788);
        chk("s5_done_cnt", done_cnt, 32'd1);

        // Reset after the 6th byte of a two-word load.
        clr_log();
        do_start(8'd2);
        send_word(32'hDEAD_BEEF, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        chk("s6_pre_in_ready", {31'd0, in_ready}, 32'd1);
        chk("s6_pre_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk_outs_zero("s6_rst");
        repeat (3) begin @(posedge clock); #1; end
        reset_n = 1'b1;
        repeat (4) begin @(posedge clock); #1; end
        chk("s6_nwrites", wr_addr.size(), 32'd1);
        chk_wr("s6_w0", 0, 32'h0, 32'hDEAD_BEEF);
        chk("s6_done_cnt", done_cnt, 32'd0);
        chk("s6_cpu_hold", {31'd0, cpu_hold}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
